snk_downsizer: RTL and testbench

SNK_DOWNSIZER -- requirements
Module: snk_downsizer

---
 rtl/snk_pkg.sv | 17 +
 rtl/snk_entry_ram.sv | 26 ++
 rtl/snk_downsizer.sv | 77 +++++++
 tb/tb_snk_downsizer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/snk_pkg.sv
// Shared widths and lane helpers for the 512-to-32 bit downsizing sink buffer.
package snk_pkg;

    localparam int unsigned SNK_IN_W   = 512;
    localparam int unsigned SNK_OUT_W  = 32;
    localparam int unsigned SNK_RATIO  = 16;
    localparam int unsigned SNK_LANE_W = 4;

    typedef logic [SNK_IN_W-1:0]   snk_entry_t;
    typedef logic [SNK_OUT_W-1:0]  snk_word_t;
    typedef logic [SNK_LANE_W-1:0] snk_lane_t;

    function automatic snk_word_t snk_lane_sel(input snk_entry_t entry, input snk_lane_t lane);
        return entry[lane*SNK_OUT_W +: SNK_OUT_W];
    endfunction

endpackage

// File: rtl/snk_entry_ram.sv
// DEPTH x 512 entry storage: one synchronous write port, one asynchronous read port.
module snk_entry_ram
    import snk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  snk_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output snk_entry_t    rdata
);

    snk_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/snk_downsizer.sv
// Circular buffer of 512-bit entries read out as 16 consecutive 32-bit words (FWFT).
module snk_downsizer
    import snk_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SNK_IN_W-1:0] din,
    input  logic                we,
    output logic                full,
    output logic [31:0]         wr_count,
    output logic [SNK_OUT_W-1:0] q,
    input  logic                re,
    output logic                empty,
    output logic [31:0]         rd_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] entries;
    snk_lane_t     lane;
    snk_entry_t    rd_entry;

    logic wr_acc;
    logic rd_acc;
    logic last_lane;
    logic entry_freed;

    assign empty       = (entries == '0);
    assign full        = (entries == CW'(DEPTH));
    assign last_lane   = (lane == SNK_LANE_W'(SNK_RATIO - 1));
    assign wr_acc      = we && !full && !rst;
    assign rd_acc      = re && !empty && !rst;
    assign entry_freed = rd_acc && last_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            entries <= '0;
            lane    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                lane <= lane + SNK_LANE_W'(1);
            end
            if (entry_freed) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            entries <= entries + CW'(wr_acc) - CW'(entry_freed);
        end
    end

    snk_entry_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Storage is never reset, so q is forced to zero while nothing is buffered.
    assign q        = empty ? '0 : snk_lane_sel(rd_entry, lane);
    assign wr_count = 32'(entries);
    assign rd_count = (32'(entries) << SNK_LANE_W) - 32'(lane);

endmodule

// File: tb/tb_snk_downsizer.sv
// Directed self-checking bench for snk_downsizer with DEPTH=4.
module tb_snk_downsizer;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] din;
    logic         we;
    logic         full;
    logic [31:0]  wr_count;
    logic [31:0]  q;
    logic         re;
    logic         empty;
    logic [31:0]  rd_count;

    int passed = 0;
    int total  = 0;

    snk_downsizer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .we       (we),
        .full     (full),
        .wr_count (wr_count),
        .q        (q),
        .re       (re),
        .empty    (empty),
        .rd_count (rd_count)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mkword(input logic [31:0] base);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [31:0] base);
        din = mkword(base);
        we  = 1'b1;
        tick();
        we  = 1'b0;
    endtask

    task automatic read_n(input int n);
        re = 1'b1;
        repeat (n) tick();
        re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; re = 1'b1; din = mkword(32'hDEAD_0000);
        tick(); tick();
        rst = 1'b0; we = 1'b0; re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
        total++; if (wr_count !== 32'd0) $display("FAIL reset_wr_count got=%0d exp=0", wr_count); else passed++;
        total++; if (rd_count !== 32'd0) $display("FAIL reset_rd_count got=%0d exp=0", rd_count); else passed++;
        total++; if (q !== 32'd0) $display("FAIL reset_q got=%h exp=0", q); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        write_entry(32'h1000);
        re = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (q !== 32'h1000 + 32'(i)) $display("FAIL single_q[%0d] got=%h exp=%h", i, q, 32'h1000 + 32'(i)); else passed++;
            total++; if (rd_count !== 32'(16 - i)) $display("FAIL single_rd_count[%0d] got=%0d exp=%0d", i, rd_count, 16 - i); else passed++;
            total++; if (empty !== 1'b0) $display("FAIL single_empty[%0d] got=%b exp=0", i, empty); else passed++;
            tick();
        end
        re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL single_empty_end got=%b exp=1", empty); else passed++;
        total++; if (rd_count !== 32'd0) $display("FAIL single_rd_count_end got=%0d exp=0", rd_count); else passed++;
    endtask

    task automatic test_full();
        logic [31:0] bases [4];
        bases = '{32'h2000, 32'h3000, 32'h4000, 32'h5000};
        do_reset();
        for (int e = 0; e < 3; e++) write_entry(bases[e]);
        total++; if (full !== 1'b0) $display("FAIL full_after3 got=%b exp=0", full); else passed++;
        write_entry(bases[3]);
        total++; if (full !== 1'b1) $display("FAIL full_after4 got=%b exp=1", full); else passed++;
        total++; if (wr_count !== 32'd4) $display("FAIL full_wr_count got=%0d exp=4", wr_count); else passed++;
        total++; if (rd_count !== 32'd64) $display("FAIL full_rd_count got=%0d exp=64", rd_count); else passed++;
        write_entry(32'h6000);
        total++; if (wr_count !== 32'd4) $display("FAIL full_overflow_wr_count got=%0d exp=4", wr_count); else passed++;
        re = 1'b1;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 16; k++) begin
                total++; if (q !== bases[e] + 32'(k)) $display("FAIL full_q[%0d][%0d] got=%h exp=%h", e, k, q, bases[e] + 32'(k)); else passed++;
                tick();
            end
        end
        re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL full_drained_empty got=%b exp=1", empty); else passed++;
    endtask

    task automatic test_rw_full();
        logic [31:0] bases [4];
        bases = '{32'h10000, 32'h20000, 32'h30000, 32'h40000};
        do_reset();
        for (int e = 0; e < 4; e++) write_entry(bases[e]);
        read_n(15);
        din = mkword(32'h70000); we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        total++; if (full !== 1'b0) $display("FAIL rwfull_full got=%b exp=0", full); else passed++;
        total++; if (wr_count !== 32'd3) $display("FAIL rwfull_wr_count got=%0d exp=3", wr_count); else passed++;
        total++; if (rd_count !== 32'd48) $display("FAIL rwfull_rd_count got=%0d exp=48", rd_count); else passed++;
        re = 1'b1;
        for (int e = 1; e < 4; e++) begin
            for (int k = 0; k < 16; k++) begin
                total++; if (q !== bases[e] + 32'(k)) $display("FAIL rwfull_q[%0d][%0d] got=%h exp=%h", e, k, q, bases[e] + 32'(k)); else passed++;
                tick();
            end
        end
        re = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL rwfull_dropped_empty got=%b exp=1", empty); else passed++;
    endtask

    task automatic test_rw_one();
        do_reset();
        write_entry(32'hA000);
        read_n(15);
        din = mkword(32'hB000); we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        total++; if (wr_count !== 32'd1) $display("FAIL rwone_wr_count got=%0d exp=1", wr_count); else passed++;
        total++; if (rd_count !== 32'd16) $display("FAIL rwone_rd_count got=%0d exp=16", rd_count); else passed++;
        total++; if (q !== 32'hB000) $display("FAIL rwone_q got=%h exp=0000b000", q); else passed++;
        read_n(15);
        total++; if (q !== 32'hB00F) $display("FAIL rwone_last_q got=%h exp=0000b00f", q); else passed++;
        read_n(1);
        total++; if (empty !== 1'b1) $display("FAIL rwone_empty got=%b exp=1", empty); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_entry(32'hC000);
        write_entry(32'hC100);
        read_n(5);
        total++; if (q !== 32'hC005) $display("FAIL mid_q_before got=%h exp=0000c005", q); else passed++;
        do_reset();
        total++; if (empty !== 1'b1) $display("FAIL mid_empty got=%b exp=1", empty); else passed++;
        total++; if (wr_count !== 32'd0) $display("FAIL mid_wr_count got=%0d exp=0", wr_count); else passed++;
        total++; if (rd_count !== 32'd0) $display("FAIL mid_rd_count got=%0d exp=0", rd_count); else passed++;
        write_entry(32'hD000);
        total++; if (q !== 32'hD000) $display("FAIL mid_new_q got=%h exp=0000d000", q); else passed++;
        total++; if (rd_count !== 32'd16) $display("FAIL mid_new_rd_count got=%0d exp=16", rd_count); else passed++;
        read_n(16);
        total++; if (empty !== 1'b1) $display("FAIL mid_new_drained got=%b exp=1", empty); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        re = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (rd_count !== 32'd0 || wr_count !== 32'd0 || empty !== 1'b1)
                $display("FAIL underflow[%0d] got rd=%0d wr=%0d empty=%b exp 0 0 1", i, rd_count, wr_count, empty); else passed++;
        end
        re = 1'b0;
        write_entry(32'hE000);
        total++; if (q !== 32'hE000) $display("FAIL underflow_q got=%h exp=0000e000", q); else passed++;
        total++; if (rd_count !== 32'd16) $display("FAIL underflow_rd_count got=%0d exp=16", rd_count); else passed++;
        read_n(1);
        total++; if (q !== 32'hE001) $display("FAIL underflow_q1 got=%h exp=0000e001", q); else passed++;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; din = '0;
        test_reset();
        test_single();
        test_full();
        test_rw_full();
        test_rw_one();
        test_reset_mid();
        test_underflow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
